wb_arbiter: RTL and testbench

- Write-back arbiter sitting directly upstream of the 16x16-bit register file.
- Merges two write-back sources (ALU results and memory load results) onto the single regfile write port (regWrite/writeAddr/writeData).
- Load results are buffered in a small FIFO; ALU results have priority, bounded by a starvation limit and a same-register ordering rule.

---
 rtl/wb_arbiter_if.sv | 44 ++++
 rtl/wb_arbiter.sv | 112 +++++++++++
 tb/tb_wb_arbiter.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter_if
// Purpose  : ALU / load write-back request bus and regfile write port bundle.
// Revision : 1.0
// ============================================================================
interface wb_arbiter_if #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int c_cntW = $clog2(FIFO_DEPTH + 1);

  logic                   alu_valid;
  logic [ADDR_W-1:0]      alu_addr;
  logic [DATA_W-1:0]      alu_data;
  logic                   alu_ready;
  logic                   mem_valid;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_data;
  logic                   mem_ready;
  logic                   reg_write;
  logic [ADDR_W-1:0]      write_addr;
  logic [DATA_W-1:0]      write_data;
  logic [2**ADDR_W-1:0]   pending_mask;
  logic [c_cntW-1:0]      fifo_count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  reg_write, write_addr, write_data,
    input  pending_mask, fifo_count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output reg_write, write_addr, write_data,
    output pending_mask, fifo_count
  );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : wb_arbiter
// Purpose  : Merges ALU and buffered load results onto the regfile write port.
// Revision : 1.0
// ============================================================================
module wb_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3
) (
  input wire clk,
  input wire reset,
  wb_arbiter_if.slave bus
);
  localparam int c_ptrW    = $clog2(FIFO_DEPTH);
  localparam int c_cntW    = $clog2(FIFO_DEPTH + 1);
  localparam int c_starveW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int c_regs    = 2 ** ADDR_W;

  logic [ADDR_W-1:0]    r_fifoAddr [FIFO_DEPTH];
  logic [DATA_W-1:0]    r_fifoData [FIFO_DEPTH];
  logic [c_ptrW-1:0]    r_head;
  logic [c_ptrW-1:0]    r_tail;
  logic [c_cntW-1:0]    r_count;
  logic [c_starveW-1:0] r_starveCnt;
  logic                 r_regWrite;
  logic [ADDR_W-1:0]    r_writeAddr;
  logic [DATA_W-1:0]    r_writeData;

  logic [c_regs-1:0]    w_pendingMask;
  logic                 w_nonEmpty;
  logic                 w_starveHit;
  logic                 w_conflict;
  logic                 w_aluReady;
  logic                 w_memReady;
  logic                 w_aluGrant;
  logic                 w_pop;
  logic                 w_push;

  // Only the occupied slots, counted from the head, contribute to the hazard mask.
  always_comb begin
    w_pendingMask = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (c_cntW'(k) < r_count)
        w_pendingMask[r_fifoAddr[r_head + c_ptrW'(k)]] = 1'b1;
    end
  end

  assign w_nonEmpty  = (r_count != '0);
  assign w_starveHit = (r_starveCnt == c_starveW'(STARVE_LIMIT));
  assign w_conflict  = w_pendingMask[bus.alu_addr];
  assign w_aluReady  = reset && !(w_nonEmpty && (w_starveHit || w_conflict));
  assign w_memReady  = reset && (r_count < c_cntW'(FIFO_DEPTH));
  assign w_aluGrant  = bus.alu_valid && w_aluReady;
  assign w_pop       = w_nonEmpty && !w_aluGrant;
  assign w_push      = bus.mem_valid && w_memReady;

  // Storage carries no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifoAddr[r_tail] <= bus.mem_addr;
      r_fifoData[r_tail] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_starveCnt <= '0;
      r_regWrite  <= 1'b0;
      r_writeAddr <= '0;
      r_writeData <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + c_ptrW'(1);
      if (w_pop)
        r_head <= r_head + c_ptrW'(1);
      r_count <= r_count + c_cntW'(w_push) - c_cntW'(w_pop);

      if (w_aluGrant) begin
        r_regWrite  <= 1'b1;
        r_writeAddr <= bus.alu_addr;
        r_writeData <= bus.alu_data;
      end else if (w_pop) begin
        r_regWrite  <= 1'b1;
        r_writeAddr <= r_fifoAddr[r_head];
        r_writeData <= r_fifoData[r_head];
      end else begin
        r_regWrite  <= 1'b0;
      end

      // Counts ALU wins over a waiting load; any pop or an empty FIFO forgives.
      if (!w_nonEmpty || w_pop)
        r_starveCnt <= '0;
      else if (w_aluGrant && !w_starveHit)
        r_starveCnt <= r_starveCnt + c_starveW'(1);
    end
  end

  assign bus.alu_ready    = w_aluReady;
  assign bus.mem_ready    = w_memReady;
  assign bus.reg_write    = r_regWrite;
  assign bus.write_addr   = r_writeAddr;
  assign bus.write_data   = r_writeData;
  assign bus.pending_mask = w_pendingMask;
  assign bus.fifo_count   = r_count;
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_arbiter
// Purpose  : Self-checking bench for wb_arbiter against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_wb_arbiter;
  localparam int STARVE_LIMIT = 3;
  localparam int FIFO_DEPTH   = 4;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } ent_t;

  logic clk;
  logic reset;
  bit   chkEn;
  int   checks;
  int   errors;

  ent_t        q[$];
  int          mStarve;
  logic        mRegWrite;
  logic [3:0]  mAddr;
  logic [15:0] mData;
  logic [19:0] wlog[$];

  logic        sAluReady, sMemReady, sRegWrite, aluAcc, memAcc;
  logic [3:0]  sAddr;
  logic [15:0] sData, sMask;
  logic [2:0]  sCount;

  wb_arbiter_if #(.DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  wb_arbiter #(
    .DATA_W(16), .ADDR_W(4), .FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] modelMask();
    logic [15:0] m;
    m = '0;
    foreach (q[i]) m[q[i].a] = 1'b1;
    return m;
  endfunction

  function automatic logic expAluReady();
    logic [15:0] m;
    m = modelMask();
    return reset && !((q.size() != 0) && (mStarve == STARVE_LIMIT || m[bus.alu_addr]));
  endfunction

  function automatic logic expMemReady();
    return reset && (q.size() < FIFO_DEPTH);
  endfunction

  // Reference model: one transaction per edge from the grant rules.
  always @(posedge clk) begin
    logic aluG, pop, push, ne;
    ent_t e;
    if (!reset) begin
      q.delete();
      mStarve   = 0;
      mRegWrite = 1'b0;
      mAddr     = '0;
      mData     = '0;
    end else begin
      ne   = (q.size() != 0);
      aluG = bus.alu_valid && expAluReady();
      pop  = ne && !aluG;
      push = bus.mem_valid && expMemReady();
      if (aluG) begin
        mRegWrite = 1'b1; mAddr = bus.alu_addr; mData = bus.alu_data;
      end else if (pop) begin
        e = q.pop_front();
        mRegWrite = 1'b1; mAddr = e.a; mData = e.d;
      end else begin
        mRegWrite = 1'b0;
      end
      if (push) q.push_back({bus.mem_addr, bus.mem_data});
      if (!ne || pop) mStarve = 0;
      else if (aluG && mStarve < STARVE_LIMIT) mStarve++;
    end
  end

  always @(negedge clk) begin
    if (chkEn) begin
      check("alu_ready",    bus.alu_ready,    expAluReady());
      check("mem_ready",    bus.mem_ready,    expMemReady());
      check("reg_write",    bus.reg_write,    mRegWrite);
      check("write_addr",   bus.write_addr,   mAddr);
      check("write_data",   bus.write_data,   mData);
      check("fifo_count",   bus.fifo_count,   q.size());
      check("pending_mask", bus.pending_mask, modelMask());
      if (bus.reg_write) wlog.push_back({bus.write_addr, bus.write_data});
    end
  end

  // Sample before the edge, then return to just after it to drive.
  task automatic cycle();
    @(negedge clk);
    sAluReady = bus.alu_ready;  sMemReady = bus.mem_ready;
    sRegWrite = bus.reg_write;  sAddr = bus.write_addr;  sData = bus.write_data;
    sMask = bus.pending_mask;   sCount = bus.fifo_count;
    aluAcc = bus.alu_valid && bus.alu_ready;
    memAcc = bus.mem_valid && bus.mem_ready;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [19:0] expLog[$];
    int ld;
    checks = 0; errors = 0; chkEn = 1'b0;
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_addr = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_addr = '0; bus.mem_data = '0;

    // Reset
    @(posedge clk); #1 chkEn = 1'b1;
    cycle();
    check("rst_reg_write", sRegWrite, 0);
    check("rst_count", sCount, 0);
    check("rst_mask", sMask, 0);
    check("rst_alu_ready_low", sAluReady, 0);
    check("rst_mem_ready_low", sMemReady, 0);
    reset = 1'b1;
    cycle();
    check("post_rst_mem_ready", sMemReady, 1);
    check("post_rst_alu_ready", sAluReady, 1);
    check("post_rst_reg_write", sRegWrite, 0);

    // ALU only
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd3; bus.alu_data = 16'hBEEF;
    cycle();
    bus.alu_valid = 1'b0;
    cycle();
    check("alu_wr", sRegWrite, 1);
    check("alu_addr", sAddr, 3);
    check("alu_data", sData, 16'hBEEF);
    cycle();
    check("alu_wr_drop", sRegWrite, 0);

    // Fill FIFO against a persistent ALU stream
    wlog.delete();
    ld = 1;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd1; bus.mem_data = 16'h1001;
    for (int c = 0; c < 14; c++) begin
      bus.alu_valid = (c >= 1 && c <= 5); bus.alu_addr = 4'd9; bus.alu_data = 16'hA9A9;
      cycle();
      if (c == 4) begin
        check("full_mem_ready", sMemReady, 0);
        check("full_count", sCount, 4);
        check("starve_alu_ready", sAluReady, 0);
      end
      if (memAcc) begin
        ld++;
        if (ld <= 5) begin bus.mem_addr = 4'(ld); bus.mem_data = 16'h1000 + 16'(ld); end
        else bus.mem_valid = 1'b0;
      end
    end
    expLog = '{{4'd9,16'hA9A9}, {4'd9,16'hA9A9}, {4'd9,16'hA9A9}, {4'd1,16'h1001},
               {4'd9,16'hA9A9}, {4'd2,16'h1002}, {4'd3,16'h1003}, {4'd4,16'h1004},
               {4'd5,16'h1005}};
    check("fill_log_len", wlog.size(), expLog.size());
    for (int i = 0; i < expLog.size() && i < wlog.size(); i++) check("fill_order", wlog[i], expLog[i]);

    // Same-register conflict
    wlog.delete();
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd7; bus.mem_data = 16'h1111;
    cycle();
    bus.mem_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_addr = 4'd7; bus.alu_data = 16'h2222;
    cycle();
    check("conflict_alu_ready", sAluReady, 0);
    check("conflict_mask", sMask, 16'h0080);
    cycle();
    check("conflict_cleared_mask", sMask, 0);
    check("conflict_alu_accept", aluAcc, 1);
    bus.alu_valid = 1'b0;
    cycle(); cycle();
    check("conflict_log_len", wlog.size(), 2);
    if (wlog.size() == 2) begin
      check("conflict_first", wlog[0], {4'd7, 16'h1111});
      check("conflict_second", wlog[1], {4'd7, 16'h2222});
    end

    // Push/pop at count 2 with pointer wrap
    wlog.delete();
    ld = 0;
    bus.mem_valid = 1'b1; bus.mem_addr = 4'd0; bus.mem_data = 16'h0000;
    for (int c = 0; c < 18; c++) begin
      bus.alu_valid = (c < 2); bus.alu_addr = 4'd15; bus.alu_data = 16'hFFFF;
      cycle();
      if (c == 3 || c == 6) check("pushpop_count", sCount, 2);
      if (memAcc) begin
        ld++;
        if (ld < 10) begin bus.mem_addr = 4'(ld); bus.mem_data = 16'(ld); end
        else bus.mem_valid = 1'b0;
      end
    end
    check("wrap_log_len", wlog.size(), 12);
    if (wlog.size() == 12) begin
      check("wrap_alu0", wlog[0], {4'd15, 16'hFFFF});
      check("wrap_alu1", wlog[1], {4'd15, 16'hFFFF});
      for (int i = 0; i < 10; i++) check("wrap_order", wlog[2+i], {4'(i), 16'(i)});
    end

    // Reset in the middle of traffic
    for (int c = 0; c < 3; c++) begin
      bus.alu_valid = 1'b1; bus.alu_addr = 4'd15; bus.alu_data = 16'h7777;
      bus.mem_valid = 1'b1; bus.mem_addr = 4'(c + 1); bus.mem_data = 16'h5000 + 16'(c);
      cycle();
    end
    reset = 1'b0;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    cycle();
    check("mid_count_before", sCount, 3);
    check("mid_wr_before", sRegWrite, 1);
    check("mid_alu_ready_low", sAluReady, 0);
    check("mid_mem_ready_low", sMemReady, 0);
    reset = 1'b1;
    cycle();
    check("mid_count_after", sCount, 0);
    check("mid_wr_after", sRegWrite, 0);
    check("mid_mask_after", sMask, 0);
    wlog.delete();
    repeat (8) cycle();
    check("mid_no_stale", wlog.size(), 0);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (!bus.alu_valid || aluAcc) begin
        bus.alu_valid = ($urandom_range(0, 9) < 6);
        bus.alu_addr  = 4'($urandom_range(0, 3));
        bus.alu_data  = 16'($urandom);
      end
      if (!bus.mem_valid || memAcc) begin
        bus.mem_valid = ($urandom_range(0, 9) < 6);
        bus.mem_addr  = 4'($urandom_range(0, 3));
        bus.mem_data  = 16'($urandom);
      end
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 299) == 0) reset = 1'b0;
    end
    reset = 1'b1;
    bus.alu_valid = 1'b0; bus.mem_valid = 1'b0;
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
